// File: rtl/axi4lite_reg_master.sv
// axi4lite_reg_master: single-outstanding AXI4-Lite initiator behind a simple
// command/response port. All AXI and response outputs come straight from flops.
module axi4lite_reg_master #(
    parameter int         ADDR_WIDTH  = 32,
    parameter int         DATA_WIDTH  = 32,
    parameter logic [2:0] PROT_VALUE  = 3'b000,
    parameter logic [3:0] CACHE_VALUE = 4'b0000
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    // response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  busy,
    // write address channel
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [3:0]            AWCACHE,
    output logic [2:0]            AWPROT,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    // write data channel
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [3:0]            WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,
    // write response channel
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    // read address channel
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [3:0]            ARCACHE,
    output logic [2:0]            ARPROT,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    // read data channel
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    state_t state;
    state_t next_state;
    logic   aw_done;
    logic   w_done;
    logic   aw_done_nx;
    logic   w_done_nx;
    logic   cmd_accept;

    assign AWCACHE = CACHE_VALUE;
    assign ARCACHE = CACHE_VALUE;
    assign AWPROT  = PROT_VALUE;
    assign ARPROT  = PROT_VALUE;

    // Next-state decode; the AW and W channels complete independently in WR_REQ.
    always_comb begin
        next_state = state;
        cmd_accept = cmd_valid && cmd_ready;
        aw_done_nx = aw_done || (AWVALID && AWREADY);
        w_done_nx  = w_done  || (WVALID && WREADY);
        case (state)
            IDLE:    if (cmd_accept) next_state = cmd_write ? WR_REQ : RD_REQ;
            WR_REQ:  if (aw_done_nx && w_done_nx) next_state = WR_RESP;
            WR_RESP: if (BVALID && BREADY) next_state = RSP;
            RD_REQ:  if (ARVALID && ARREADY) next_state = RD_DATA;
            RD_DATA: if (RVALID && RREADY) next_state = RSP;
            RSP:     if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= IDLE;
        else        state <= next_state;
    end

    // Registered handshake, address/data and response outputs.
    // cmd_ready/busy are computed from next_state so that they are true flops,
    // yet still line up with the state they describe.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            AWADDR    <= '0;
            ARADDR    <= '0;
            WDATA     <= '0;
            WSTRB     <= '0;
            AWVALID   <= 1'b0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else begin
            cmd_ready <= (next_state == IDLE);
            busy      <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    if (cmd_accept) begin
                        rsp_write <= cmd_write;
                        if (cmd_write) begin
                            AWADDR  <= cmd_addr;
                            WDATA   <= cmd_wdata;
                            WSTRB   <= cmd_wstrb;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                        end else begin
                            ARADDR  <= cmd_addr;
                            ARVALID <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    if (AWREADY) AWVALID <= 1'b0;
                    if (WREADY)  WVALID  <= 1'b0;
                    aw_done <= aw_done_nx;
                    w_done  <= w_done_nx;
                    if (aw_done_nx && w_done_nx) BREADY <= 1'b1;
                end
                WR_RESP: begin
                    if (BVALID) begin
                        rsp_resp  <= BRESP;
                        rsp_rdata <= '0;
                        BREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (RVALID) begin
                        rsp_rdata <= RDATA;
                        rsp_resp  <= RRESP;
                        RREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_reg_master.sv
// tb_axi4lite_reg_master: scoreboard bench with a wait-state slave model,
// protocol checker and reference memory.
module tb_axi4lite_reg_master;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  AWCACHE, ARCACHE, WSTRB;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    axi4lite_reg_master #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .PROT_VALUE (3'b010),
        .CACHE_VALUE(4'b0011)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
        .AWADDR(AWADDR), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct { bit wr; logic [31:0] rdata; logic [1:0] resp; int acc; int lat; } rsp_t;
    typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } bus_t;

    rsp_t exp_rsp[$];
    bus_t exp_bus[$];
    logic [31:0] smem[logic [31:0]];
    logic [31:0] refm[logic [31:0]];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_hs_cyc = -1;

    // slave configuration, written by the main sequence only
    bit       rnd_mode = 1'b0;
    bit       rsp_force = 1'b1;
    int       aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event observed/absent contrary to requirement (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_s(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return refm.exists(a) ? refm[a] : 32'h0;
    endfunction

    function automatic int dly(input int cfg);
        return rnd_mode ? int'($urandom_range(0, 3)) : cfg;
    endfunction

    initial forever begin
        @(posedge ACLK);
        cyc++;
    end

    // response-port consumer
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge ACLK); #1;
            rsp_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : rsp_force;
        end
    end

    // AXI4-Lite slave model with per-channel READY/VALID wait states
    int  aw_cnt = -1, w_cnt = -1, b_cnt = -1, ar_cnt = -1, r_cnt = -1;
    bit  aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    logic [31:0] s_awaddr, s_wdata, s_raddr;
    logic [3:0]  s_wstrb;
    initial begin : slave
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        logic [31:0] c_awaddr, c_wdata, c_araddr;
        logic [3:0]  c_wstrb;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        forever begin
            @(negedge ACLK);
            aw_hs = AWVALID && AWREADY;  c_awaddr = AWADDR;
            w_hs  = WVALID && WREADY;    c_wdata = WDATA; c_wstrb = WSTRB;
            b_hs  = BVALID && BREADY;
            ar_hs = ARVALID && ARREADY;  c_araddr = ARADDR;
            r_hs  = RVALID && RREADY;
            @(posedge ACLK); #1;
            if (ARESET) begin
                AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
                aw_cnt = -1; w_cnt = -1; b_cnt = -1; ar_cnt = -1; r_cnt = -1;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                continue;
            end
            if (aw_hs) begin AWREADY = 0; aw_cnt = -1; s_awaddr = c_awaddr; aw_got = 1; end
            if (w_hs)  begin WREADY = 0; w_cnt = -1; s_wdata = c_wdata; s_wstrb = c_wstrb; w_got = 1; end
            if (aw_got && w_got) begin
                smem[s_awaddr] = merge(rd_s(s_awaddr), s_wdata, s_wstrb);
                aw_got = 0; w_got = 0; b_pend = 1; b_cnt = dly(b_delay);
            end
            if (b_hs) BVALID = 0;
            if (b_pend && !BVALID) begin
                if (b_cnt <= 0) begin BVALID = 1; BRESP = bresp_cfg; b_pend = 0; end
                else b_cnt--;
            end
            if (ar_hs) begin ARREADY = 0; ar_cnt = -1; s_raddr = c_araddr; r_pend = 1; r_cnt = dly(r_delay); end
            if (r_hs) RVALID = 0;
            if (r_pend && !RVALID) begin
                if (r_cnt <= 0) begin RVALID = 1; RDATA = rd_s(s_raddr); RRESP = rresp_cfg; r_pend = 0; end
                else r_cnt--;
            end
            if (AWVALID && !AWREADY) begin
                if (aw_cnt < 0) aw_cnt = dly(aw_delay);
                if (aw_cnt == 0) AWREADY = 1; else aw_cnt--;
            end
            if (WVALID && !WREADY) begin
                if (w_cnt < 0) w_cnt = dly(w_delay);
                if (w_cnt == 0) WREADY = 1; else w_cnt--;
            end
            if (ARVALID && !ARREADY) begin
                if (ar_cnt < 0) ar_cnt = dly(ar_delay);
                if (ar_cnt == 0) ARREADY = 1; else ar_cnt--;
            end
        end
    end

    // monitor: protocol checker, bus-channel scoreboard, response scoreboard
    initial begin : monitor
        bit prev_rst = 1;
        bit aw_chk = 0, w_chk = 0, rsp_seen = 0;
        int tx_aw = 0, tx_w = 0, tx_b = 0, tx_ar = 0, tx_r = 0;
        logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0, p_rspv = 0, p_rspr = 0, p_rspw = 0;
        logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0, p_rdata = 0;
        logic [3:0]  p_wstrb = 0;
        logic [1:0]  p_resp = 0;
        rsp_t e;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                prev_rst = 1; aw_chk = 0; w_chk = 0; rsp_seen = 0;
                tx_aw = 0; tx_w = 0; tx_b = 0; tx_ar = 0; tx_r = 0;
            end else begin
                if (!prev_rst) begin
                    if (p_awv && !p_awr) chk("aw_hold", 64'({AWVALID, AWADDR}), 64'({1'b1, p_awaddr}));
                    if (p_awv && p_awr)  chk("aw_drop", 64'(AWVALID), 64'(1'b0));
                    if (p_wv && !p_wr)   chk("w_hold", 64'({WVALID, WSTRB, WDATA}), 64'({1'b1, p_wstrb, p_wdata}));
                    if (p_wv && p_wr)    chk("w_drop", 64'(WVALID), 64'(1'b0));
                    if (p_arv && !p_arr) chk("ar_hold", 64'({ARVALID, ARADDR}), 64'({1'b1, p_araddr}));
                    if (p_arv && p_arr)  chk("ar_drop", 64'(ARVALID), 64'(1'b0));
                    if (p_rspv && !p_rspr)
                        chk("rsp_hold", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}),
                            64'({1'b1, p_rspw, p_resp, p_rdata}));
                end
                if (BREADY) chk("bready_after_aw_w", 64'(tx_aw != 0 && tx_w != 0), 64'(1'b1));
                if (cmd_valid && cmd_ready) begin
                    tx_aw = 0; tx_w = 0; tx_b = 0; tx_ar = 0; tx_r = 0;
                end
                if (AWVALID && AWREADY) begin
                    tx_aw++;
                    if (exp_bus.size() == 0 || !exp_bus[0].wr) note_fail("aw_unexpected");
                    else begin chk("awaddr", 64'(AWADDR), 64'(exp_bus[0].addr)); aw_chk = 1; end
                end
                if (WVALID && WREADY) begin
                    tx_w++;
                    if (exp_bus.size() == 0 || !exp_bus[0].wr) note_fail("w_unexpected");
                    else begin
                        chk("wdata_wstrb", 64'({WSTRB, WDATA}), 64'({exp_bus[0].strb, exp_bus[0].data}));
                        w_chk = 1;
                    end
                end
                if (aw_chk && w_chk) begin void'(exp_bus.pop_front()); aw_chk = 0; w_chk = 0; end
                if (ARVALID && ARREADY) begin
                    tx_ar++;
                    if (exp_bus.size() == 0 || exp_bus[0].wr) note_fail("ar_unexpected");
                    else begin chk("araddr", 64'(ARADDR), 64'(exp_bus[0].addr)); void'(exp_bus.pop_front()); end
                end
                if (BVALID && BREADY) tx_b++;
                if (RVALID && RREADY) tx_r++;
                if (rsp_valid) begin
                    chk("cmd_ready_during_rsp", 64'(cmd_ready), 64'(1'b0));
                    if (exp_rsp.size() == 0) begin
                        if (!rsp_seen) note_fail("rsp_unexpected");
                        rsp_seen = !rsp_ready;
                    end else begin
                        e = exp_rsp[0];
                        if (!rsp_seen) begin
                            rsp_seen = 1;
                            if (e.lat >= 0) chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
                        end
                        if (rsp_ready) begin
                            chk("rsp_write", 64'(rsp_write), 64'(e.wr));
                            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                            chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                            if (e.wr) begin
                                chk("aw_count", 64'(tx_aw), 64'(1));
                                chk("w_count", 64'(tx_w), 64'(1));
                                chk("b_count", 64'(tx_b), 64'(1));
                            end else begin
                                chk("ar_count", 64'(tx_ar), 64'(1));
                                chk("r_count", 64'(tx_r), 64'(1));
                            end
                            void'(exp_rsp.pop_front());
                            rsp_seen = 0;
                            last_hs_cyc = cyc;
                        end
                    end
                end
                prev_rst = 0;
            end
            p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR;
            p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA; p_wstrb = WSTRB;
            p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR;
            p_rspv = rsp_valid; p_rspr = rsp_ready; p_rspw = rsp_write;
            p_rdata = rsp_rdata; p_resp = rsp_resp;
        end
    end

    // present one command once the master is idle; expectations pushed on issue
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [1:0] resp,
                         input logic [31:0] exp_rdata, input int lat, output int acc);
        rsp_t r;
        bus_t b;
        acc = -1;
        for (int k = 0; k < 200 && !cmd_ready; k++) begin @(posedge ACLK); #2; end
        if (!cmd_ready) begin note_fail("cmd_ready_timeout"); return; end
        bresp_cfg = resp;
        rresp_cfg = resp;
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        cmd_valid = 1'b1;
        acc = cyc;
        r.wr = wr; r.rdata = wr ? 32'h0 : exp_rdata; r.resp = resp; r.acc = acc; r.lat = lat;
        b.wr = wr; b.addr = addr; b.data = data; b.strb = strb;
        exp_rsp.push_back(r);
        exp_bus.push_back(b);
        if (wr) refm[addr] = merge(rd_ref(addr), data, strb);
        @(posedge ACLK); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && !(cmd_ready && exp_rsp.size() == 0); k++) begin @(posedge ACLK); #2; end
        if (!(cmd_ready && exp_rsp.size() == 0)) note_fail("idle_timeout");
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc;
        logic [31:0] a, d, x;
        bit wr;
        ARESET = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        smem[32'h4] = 32'h1234_5678;
        refm[32'h4] = 32'h1234_5678;
        repeat (3) @(posedge ACLK);
        #2;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1'b0));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_valids", 64'({AWVALID, WVALID, ARVALID, rsp_valid}), 64'(4'b0));
        chk("rst_readies", 64'({BREADY, RREADY}), 64'(2'b0));
        chk("rst_addr", 64'({AWADDR, ARADDR}), 64'(0));
        chk("rst_wdata_wstrb", 64'({WSTRB, WDATA}), 64'(0));
        chk("rst_rsp_fields", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'(0));
        chk("cache_prot", 64'({AWCACHE, ARCACHE, AWPROT, ARPROT}), 64'({4'b0011, 4'b0011, 3'b010, 3'b010}));
        ARESET = 1'b0;
        @(posedge ACLK); #2;

        // basic write and read, zero-wait slave
        issue(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0, 3, acc);
        issue(0, 32'h4, 32'h0, 4'h0, 2'b00, 32'h1234_5678, 3, acc);

        // W well ahead of AW, then AW well ahead of W
        wait_idle(); aw_delay = 3; w_delay = 0;
        issue(1, 32'h30, 32'hA5A5_0001, 4'hF, 2'b00, 32'h0, 6, acc);
        wait_idle(); aw_delay = 0; w_delay = 3;
        issue(1, 32'h34, 32'h5A5A_0002, 4'b1001, 2'b00, 32'h0, 6, acc);
        wait_idle(); w_delay = 0;

        // late SLVERR write response with response-port backpressure
        b_delay = 4; rsp_force = 0;
        issue(1, 32'h20, 32'hCAFE_F00D, 4'b0011, 2'b10, 32'h0, 7, acc);
        for (int k = 0; k < 50 && !rsp_valid; k++) begin @(posedge ACLK); #2; end
        repeat (5) begin @(posedge ACLK); #2; end
        chk("bp_rsp_valid", 64'(rsp_valid), 64'(1'b1));
        chk("bp_rsp_resp", 64'(rsp_resp), 64'(2'b10));
        chk("bp_cmd_ready", 64'(cmd_ready), 64'(1'b0));
        rsp_force = 1; b_delay = 0;
        issue(0, 32'h20, 32'h0, 4'h0, 2'b00, 32'h0000_F00D, 3, acc);
        chk("accept_after_rsp", 64'(acc), 64'(last_hs_cyc + 1));

        // reset while ARVALID waits for ARREADY
        wait_idle(); ar_delay = 1000;
        issue(0, 32'h8, 32'h0, 4'h0, 2'b00, 32'h0, -1, acc);
        repeat (2) begin @(posedge ACLK); #2; end
        chk("pre_rst_arvalid", 64'(ARVALID), 64'(1'b1));
        #1 ARESET = 1'b1;
        #1;
        chk("mid_rst_arvalid", 64'(ARVALID), 64'(1'b0));
        chk("mid_rst_busy", 64'(busy), 64'(1'b0));
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
        exp_rsp.delete();
        exp_bus.delete();
        @(posedge ACLK); #2;
        ar_delay = 0;
        ARESET = 1'b0;
        issue(1, 32'h8, 32'h5555_AAAA, 4'hF, 2'b00, 32'h0, 3, acc);
        issue(0, 32'h8, 32'h0, 4'h0, 2'b11, 32'h5555_AAAA, 3, acc);

        // random stress against random wait states
        wait_idle();
        rnd_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 15)) << 2;
            d  = $urandom;
            x  = rd_ref(a);
            issue(wr, a, d, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), x, -1, acc);
        end
        for (int k = 0; k < 500 && exp_rsp.size() != 0; k++) @(posedge ACLK);
        if (exp_rsp.size() != 0) note_fail("drain_timeout");
        repeat (2) @(posedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
